// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sign helpers for the division front-end
package div_pkg;

    // Front-end sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Helpers work on a wide container; callers size-cast the result back to WIDTH,
    // which keeps the low WIDTH bits and gives exact WIDTH-bit two's-complement.
    localparam int MAXW = 64;
    typedef logic [MAXW-1:0] wide_t;

    function automatic wide_t twos_neg(input wide_t v);
        return ~v + wide_t'(1);
    endfunction

    function automatic wide_t cond_fix(input wide_t v, input logic neg);
        return neg ? twos_neg(v) : v;
    endfunction

endpackage

// File: rtl/div_frontend.sv
// rtl/div_frontend.sv - valid/ready front-end adding signed mode and divide-by-zero to an unsigned divider
module div_frontend
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_y,
    input  logic             in_signed,
    output logic             div_start,
    output logic [WIDTH-1:0] div_x,
    output logic [WIDTH-1:0] div_y,
    input  logic             div_val,
    input  logic [WIDTH-1:0] div_q,
    input  logic [WIDTH-1:0] div_r,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] out_r,
    output logic             out_dbz,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic             sgn_r;
    logic             sx_r;
    logic             sy_r;

    logic             sx_in;
    logic             sy_in;
    logic [WIDTH-1:0] mag_x;
    logic [WIDTH-1:0] mag_y;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    logic             is_ovf;

    // Operand signs and magnitudes seen by the divider, derived straight from the offered pair
    assign sx_in = in_signed & in_x[WIDTH-1];
    assign sy_in = in_signed & in_y[WIDTH-1];
    assign mag_x = WIDTH'(cond_fix(wide_t'(in_x), sx_in));
    assign mag_y = WIDTH'(cond_fix(wide_t'(in_y), sy_in));

    // Sign correction of the divider result: quotient truncates toward zero, remainder follows dividend
    assign q_fix  = WIDTH'(cond_fix(wide_t'(div_q), sx_r ^ sy_r));
    assign r_fix  = WIDTH'(cond_fix(wide_t'(div_r), sx_r));
    assign is_ovf = sgn_r && (x_r == MIN_VAL) && (y_r == '1);

    // Control FSM with all handshake and divider-side outputs registered
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            div_start <= 1'b0;
            div_x     <= '0;
            div_y     <= '0;
            out_valid <= 1'b0;
            out_q     <= '0;
            out_r     <= '0;
            out_dbz   <= 1'b0;
            out_ovf   <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            sgn_r     <= 1'b0;
            sx_r      <= 1'b0;
            sy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        x_r      <= in_x;
                        y_r      <= in_y;
                        sgn_r    <= in_signed;
                        sx_r     <= sx_in;
                        sy_r     <= sy_in;
                        if (in_y == '0) begin
                            // Divide-by-zero is answered locally; the divider is never started
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_q     <= '0;
                            out_r     <= in_x;
                            out_dbz   <= 1'b1;
                            out_ovf   <= 1'b0;
                        end else begin
                            state     <= ISSUE;
                            div_start <= 1'b1;
                            div_x     <= mag_x;
                            div_y     <= mag_y;
                        end
                    end
                end
                ISSUE: begin
                    div_start <= 1'b0;
                    state     <= WAIT;
                end
                WAIT: begin
                    if (div_val) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out_dbz   <= 1'b0;
                        out_ovf   <= is_ovf;
                        out_q     <= is_ovf ? MIN_VAL : q_fix;
                        out_r     <= is_ovf ? '0 : r_fix;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_frontend.sv
// tb/tb_div_frontend.sv - scoreboard bench for div_frontend with a cycle-accurate divider model
module tb_div_frontend;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_y;
    logic             in_signed;
    logic             div_start;
    logic [WIDTH-1:0] div_x;
    logic [WIDTH-1:0] div_y;
    logic             div_val;
    logic [WIDTH-1:0] div_q;
    logic [WIDTH-1:0] div_r;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_r;
    logic             out_dbz;
    logic             out_ovf;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             dbz;
        logic             ovf;
        logic [WIDTH-1:0] dx;
        logic [WIDTH-1:0] dy;
        int               lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    div_frontend #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_signed (in_signed),
        .div_start (div_start),
        .div_x     (div_x),
        .div_y     (div_y),
        .div_val   (div_val),
        .div_q     (div_q),
        .div_r     (div_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_q     (out_q),
        .out_r     (out_r),
        .out_dbz   (out_dbz),
        .out_ovf   (out_ovf)
    );

    // Unsigned iterative divider model: start seen at edge 1, div_val high during cycle 1+WIDTH
    int               dcnt = 0;
    logic [WIDTH-1:0] mq = '0;
    logic [WIDTH-1:0] mr = '0;
    int               starts = 0;
    logic [WIDTH-1:0] last_dx = '0;
    logic [WIDTH-1:0] last_dy = '0;

    always @(posedge clk) begin
        if (div_start) begin
            starts  <= starts + 1;
            last_dx <= div_x;
            last_dy <= div_y;
            dcnt    <= 1;
            if (div_y != 0) begin
                mq <= div_x / div_y;
                mr <= div_x % div_y;
            end
        end else if (dcnt != 0) begin
            dcnt <= (dcnt == WIDTH) ? 0 : dcnt + 1;
        end
    end

    assign div_val = (dcnt == WIDTH);
    assign div_q   = mq;
    assign div_r   = mr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic edbz, input logic eovf,
                          input logic [WIDTH-1:0] edx, input logic [WIDTH-1:0] edy,
                          input int hold);
        exp_t e;
        int   guard;
        int   lat;
        int   s0;
        e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf; e.dx = edx; e.dy = edy;
        e.lat = edbz ? 1 : 2 + WIDTH;
        sb.push_back(e);

        @(negedge clk);
        in_x = x; in_y = y; in_signed = s; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            void'(sb.pop_front());
            return;
        end
        s0 = starts;
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end

        e = sb.pop_front();
        check("latency", 32'(lat), 32'(e.lat));
        check("out_q", 32'(out_q), 32'(e.q));
        check("out_r", 32'(out_r), 32'(e.r));
        check("out_dbz", 32'(out_dbz), 32'(e.dbz));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
        check("start_count", 32'(starts - s0), e.dbz ? 32'd0 : 32'd1);
        if (!e.dbz) begin
            check("div_x", 32'(last_dx), 32'(e.dx));
            check("div_y", 32'(last_dy), 32'(e.dy));
        end

        // Back-pressure: a competing operand pair is offered while the result is held
        for (int i = 0; i < hold; i++) begin
            in_x = 8'd99; in_y = 8'd9; in_signed = 1'b0; in_valid = 1'b1;
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_q", 32'(out_q), 32'(e.q));
            check("hold_r", 32'(out_r), 32'(e.r));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        if (hold > 0) check("hold_no_start", 32'(starts - s0), e.dbz ? 32'd0 : 32'd1);
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("in_ready_back", 32'(in_ready), 32'd1);
        check("q_kept", 32'(out_q), 32'(e.q));
    endtask

    initial begin
        int lat;
        int seen;
        rst = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_signed = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_x", 32'(div_x), 32'd0);
        check("rst_out_q", 32'(out_q), 32'd0);
        rst = 1'b1;

        run_op(8'd11,  8'd3,   1'b0, 8'd3,   8'd2,   1'b0, 1'b0, 8'd11,  8'd3,   0);
        run_op(8'd248, 8'd254, 1'b0, 8'd0,   8'd248, 1'b0, 1'b0, 8'd248, 8'd254, 0);
        run_op(8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0, 1'b0, 8'd7,   8'd2,   0);
        run_op(8'd7,   8'hFE,  1'b1, 8'hFD,  8'h01,  1'b0, 1'b0, 8'd7,   8'd2,   0);
        run_op(8'hF8,  8'hFE,  1'b1, 8'h04,  8'h00,  1'b0, 1'b0, 8'd8,   8'd2,   0);
        run_op(8'd10,  8'd0,   1'b1, 8'd0,   8'd10,  1'b1, 1'b0, 8'd0,   8'd0,   0);
        run_op(8'd10,  8'd0,   1'b0, 8'd0,   8'd10,  1'b1, 1'b0, 8'd0,   8'd0,   0);
        run_op(8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1, 8'h80,  8'h01,  0);
        run_op(8'h80,  8'h01,  1'b1, 8'h80,  8'h00,  1'b0, 1'b0, 8'h80,  8'h01,  0);
        run_op(8'h80,  8'hFF,  1'b0, 8'h00,  8'h80,  1'b0, 1'b0, 8'h80,  8'hFF,  0);
        run_op(8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0, 1'b0, 8'd100, 8'd7,   5);

        // Reset during WAIT: 55/11 is aborted, the divider's late div_val must be ignored
        @(negedge clk);
        in_x = 8'd55; in_y = 8'd11; in_signed = 1'b0; in_valid = 1'b1;
        lat = 0;
        while (!in_ready && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("rst_test_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_div_start", 32'(div_start), 32'd0);
        check("midrst_div_x", 32'(div_x), 32'd0);
        check("midrst_div_y", 32'(div_y), 32'd0);
        check("midrst_out_q", 32'(out_q), 32'd0);
        check("midrst_out_r", 32'(out_r), 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("late_div_val_ignored", 32'(seen), 32'd0);

        run_op(8'd55, 8'd11, 1'b0, 8'd5, 8'd0, 1'b0, 1'b0, 8'd55, 8'd11, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_frontend.md
Name: div_frontend

Overview:
- Upstream stage for the team's unsigned iterative `divider`.
- Accepts operand pairs over a valid/ready handshake and adds signed (two's-complement) division.
- Detects divide-by-zero locally, drives the divider's start/x/y, captures q/r on its val, and sign-corrects the result.
- Presents the result on a valid/ready output port, so the multi-cycle divider plugs into streaming datapaths.

Parameters:
- WIDTH, 8, operand/result width in bits; must match the attached divider's WIDTH.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- in_x  input  WIDTH  dividend.
- in_y  input  WIDTH  divisor.
- in_signed  input  1  1 = operands are two's-complement; 0 = unsigned.
- div_start  output  1  one-cycle start pulse to the divider.
- div_x  output  WIDTH  unsigned dividend magnitude to the divider.
- div_y  output  WIDTH  unsigned divisor magnitude to the divider.
- div_val  input  1  divider result valid.
- div_q  input  WIDTH  divider unsigned quotient.
- div_r  input  WIDTH  divider unsigned remainder.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_q  output  WIDTH  final quotient.
- out_r  output  WIDTH  final remainder.
- out_dbz  output  1  divide-by-zero status of this result.
- out_ovf  output  1  signed overflow status of this result.

Behaviour:
- Reset (rst==0 at a clock edge):
  - State goes to IDLE.
  - in_ready=0 during reset; 1 from the first cycle after reset in IDLE.
  - div_start=0, div_x=0, div_y=0.
  - out_valid=0, out_q=0, out_r=0, out_dbz=0, out_ovf=0.
  - Reset in any state aborts the operation with no output.
  - The divider is not reset by this block; a stale div_val seen in IDLE/DONE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register x, y and signed; latch sx = signed & x[MSB] and sy = signed & y[MSB].
  - If y==0, go to DONE with dbz=1, q=0, r=x (raw), ovf=0; no div_start is issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle):
  - div_start=1.
  - div_x = sx ? -x : x; div_y = sy ? -y : y, both computed in WIDTH bits.
  - The magnitude of the most-negative value (e.g. -128 at WIDTH 8) is 2^(WIDTH-1) as unsigned, which the divider handles.
  - div_x/div_y hold their values until the next ISSUE.
  - Go to WAIT.
- WAIT:
  - Wait for div_val with no timeout; div_start=0.
  - On div_val, capture q = (sx^sy) ? -div_q : div_q and r = sx ? -div_r : div_r.
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - ovf = signed && x==MIN && y==all-ones; q then wraps to MIN and r=0.
  - Go to DONE.
- DONE:
  - out_valid=1; out_q/out_r/out_dbz/out_ovf are stable while out_valid=1.
  - in_ready=0.
  - On out_ready, go to IDLE; out_valid drops the next cycle.
  - out_* keep their last values after the transfer (out_valid is the qualifier).
- Latency:
  - Input accepted at cycle 0; div_start in cycle 1.
  - Divider asserts div_val at cycle 1+WIDTH.
  - out_valid at cycle 2+WIDTH.
  - Divide-by-zero: out_valid at cycle 1.
- Throughput: one operation in flight; no input acceptance while out_valid is held (no skid buffer).
- Unsigned mode (in_signed=0): sx=sy=0, no negation, ovf is always 0.

Decomposition:
- Shared package div_pkg:
  - state enum (IDLE, ISSUE, WAIT, DONE).
  - function for WIDTH-bit two's-complement negate.
  - function for conditional sign fix.
- No sub-module inside this block.
- The divider is a peer instance connected at the level above (div_frontend and divider wired side by side in the datapath wrapper and in the bench).

Test Plan (WIDTH=8, bench instantiates div_frontend + divider):
- Unsigned 11/3 and 248/254: q=3,r=2 then q=0,r=248; dbz=ovf=0; out_valid exactly 10 cycles after input handshake; one div_start pulse each.
- Signed -7/2 -> q=0xFD(-3), r=0xFF(-1). Signed 7/-2 -> q=0xFD, r=1. Signed -8/-2 -> q=4, r=0. Check div_x/div_y = 7/2, 7/2, 8/2.
- Divide-by-zero 10/0 (signed and unsigned):
  - out_dbz=1, q=0, r=10.
  - out_valid in cycle 1; div_start never asserted.
- Overflow signed -128/-1 -> out_ovf=1, q=0x80, r=0; signed -128/1 -> q=0x80, ovf=0; unsigned 128/255 -> q=0, r=128, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE:
  - out_valid and out_q/out_r stay stable.
  - in_ready stays 0; a next in_valid is not accepted until the cycle after the out handshake.
- Reset mid-WAIT: rst=0 for 1 cycle at cycle 4 of a 55/11 op:
  - all outputs return to reset values; late div_val ignored, no out_valid.
  - next op 55/11 -> q=5, r=0.
